// File: rtl/mycpu_pkg.sv
// ============================================================================
//  Module      : mycpu_pkg
//  Description : Shared types and constants for the mycpu datapath/control.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mycpu_pkg;

    // PC select, driven by the control unit and consumed by pc_ir
    typedef enum logic [1:0] {
        PS_HOLD = 2'b00,
        PS_INC  = 2'b01,
        PS_BR   = 2'b10,
        PS_JMP  = 2'b11
    } pc_sel_t;

    // Branch offset is a two's-complement field split across IR[8:6] and IR[2:0]
    localparam int BR_OFS_W = 6;

endpackage

`default_nettype wire

// File: rtl/pc_ir_pc_nxt_calc.sv
// ============================================================================
//  Module      : pc_nxt_calc
//  Description : Combinational next-PC selection: hold, increment, relative
//                branch (6-bit signed offset from IR) or absolute jump.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_nxt_calc
    import mycpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [DATA_W-1:0] ir_i,
    input  pc_sel_t           ps_i,
    input  logic [ADDR_W-1:0] a_i,
    output logic [ADDR_W-1:0] pc_nxt_o
);

    logic [BR_OFS_W-1:0] w_br_ofs;
    logic [ADDR_W-1:0]   w_br_ofs_ext;
    logic                unused_ir_bits;

    assign w_br_ofs       = {ir_i[8:6], ir_i[2:0]};
    assign w_br_ofs_ext   = {{(ADDR_W-BR_OFS_W){w_br_ofs[BR_OFS_W-1]}}, w_br_ofs};
    // Remaining IR bits are opcode/register fields that do not affect the PC
    assign unused_ir_bits = ^{ir_i[DATA_W-1:9], ir_i[5:3]};

    // Select the next PC; all arithmetic wraps modulo 2^ADDR_W
    always_comb begin
        pc_nxt_o = pc_i;
        case (ps_i)
            PS_HOLD: pc_nxt_o = pc_i;
            PS_INC:  pc_nxt_o = pc_i + {{(ADDR_W-1){1'b0}}, 1'b1};
            PS_BR:   pc_nxt_o = pc_i + w_br_ofs_ext;
            PS_JMP:  pc_nxt_o = a_i;
            default: pc_nxt_o = pc_i;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/pc_ir.sv
// ============================================================================
//  Module      : pc_ir
//  Description : Program counter and instruction register stage. Drives the
//                synchronous instruction memory address, captures fetched
//                instructions, counts loads and flags stale-data captures.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_ir
    import mycpu_pkg::*;
#(
    parameter int              DATA_W   = 16,
    parameter int              ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              il_in,
    input  pc_sel_t           ps_in,
    input  logic [DATA_W-1:0] a_in,
    output logic [ADDR_W-1:0] imem_addr_out,
    input  logic [DATA_W-1:0] imem_rdata_in,
    output logic [DATA_W-1:0] ins_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              ir_valid_out,
    output logic              fetch_err_out,
    output logic [CNT_W-1:0]  insn_cnt_out
);

    logic [ADDR_W-1:0] pc_q,        pc_d;
    logic [DATA_W-1:0] ir_q,        ir_d;
    logic              ir_valid_q,  ir_valid_d;
    logic              fetch_err_q, fetch_err_d;
    logic [CNT_W-1:0]  insn_cnt_q,  insn_cnt_d;
    // Address whose data is currently on imem_rdata_in, and whether it is real
    logic [ADDR_W-1:0] tag_addr_q;
    logic              tag_vld_q;

    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_stale;

    pc_nxt_calc #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_pc_nxt_calc (
        .pc_i     (pc_q),
        .ir_i     (ir_q),
        .ps_i     (ps_in),
        .a_i      (a_in[ADDR_W-1:0]),
        .pc_nxt_o (w_pc_nxt)
    );

    assign imem_addr_out = w_pc_nxt;
    assign w_stale       = !tag_vld_q || (tag_addr_q != pc_q);

    // Next-state for PC, IR, load counter and sticky fetch error
    always_comb begin
        pc_d        = w_pc_nxt;
        ir_d        = ir_q;
        ir_valid_d  = ir_valid_q;
        insn_cnt_d  = insn_cnt_q;
        fetch_err_d = fetch_err_q;
        if (il_in) begin
            ir_d        = imem_rdata_in;
            ir_valid_d  = 1'b1;
            insn_cnt_d  = insn_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            fetch_err_d = fetch_err_q | w_stale;
        end
    end

    // State registers; reset discards any fetch in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            ir_q        <= '0;
            ir_valid_q  <= 1'b0;
            fetch_err_q <= 1'b0;
            insn_cnt_q  <= '0;
            tag_addr_q  <= '0;
            tag_vld_q   <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            ir_valid_q  <= ir_valid_d;
            fetch_err_q <= fetch_err_d;
            insn_cnt_q  <= insn_cnt_d;
            tag_addr_q  <= imem_addr_out;
            tag_vld_q   <= 1'b1;
        end
    end

    assign ins_out       = ir_q;
    assign pc_out        = pc_q;
    assign ir_valid_out  = ir_valid_q;
    assign fetch_err_out = fetch_err_q;
    assign insn_cnt_out  = insn_cnt_q;

endmodule

`default_nettype wire
